// File: rtl/mm_result_collector.sv
// Collects a streamed matrix result into a small buffer, tracks its shape and error conditions, then drains it as a ready/valid stream.
// Optional MMRC_HEADER_EN prepends a status/dimension header word to the drain stream.
module mm_result_collector #(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [11:0] in_data,
  input  logic               in_overflow,
  input  logic               in_change_row,
  input  logic               in_legal,
  input  logic               in_busy,
  input  logic               o_ready,
  output logic               o_valid,
  output logic signed [11:0] o_data,
  output logic               o_row_end,
  output logic               o_last,
  output logic [4:0]         rows,
  output logic [4:0]         cols,
  output logic               err_ovf,
  output logic               err_shape,
  output logic               err_full,
  output logic               err_illegal,
  output logic               done
);

  localparam int DATA_W = 12;
  localparam int PW     = $clog2(DEPTH + 1);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  state_t state;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, cnt_nxt, rd_nxt;
  logic [4:0]    col_cnt, rd_col, col_nxt, rows_nxt, cols_nxt, rd_col_nxt;
  logic          acc, wr_en, close, shape_bad;
  logic          ovf_nxt, full_nxt, shape_nxt, illegal_nxt;
  logic signed [DATA_W-1:0] wdata, first_word, rd_word;
`ifdef MMRC_HEADER_EN
  logic          hdr_pend;
`endif

  // An overflowed element is replaced by zero rather than a wrapped value.
  function automatic logic signed [DATA_W-1:0] clamp_elem(input logic signed [DATA_W-1:0] d,
                                                          input logic ovf);
    return ovf ? '0 : d;
  endfunction

`ifdef MMRC_HEADER_EN
  function automatic logic signed [DATA_W-1:0] header_word(input logic full, input logic ill,
                                                           input logic shp, input logic ovf,
                                                           input logic [4:0] r, input logic [4:0] c);
    logic [4:0] rm1, cm1;
    rm1 = r - 5'd1;
    cm1 = c - 5'd1;
    return {full, ill, shp, ovf, rm1[3:0], cm1[3:0]};
  endfunction
`endif

  always_comb begin
    acc         = (state == COLLECT) && in_valid;
    wr_en       = acc && (wr_ptr < PW'(DEPTH));
    wdata       = clamp_elem(in_data, in_overflow);
    col_nxt     = col_cnt + {4'd0, acc};
    // A row closes on an explicit marker, or implicitly when the job ends mid-row.
    close       = (state == COLLECT) &&
                  ((acc && in_change_row) || (!in_busy && col_nxt != 5'd0));
    shape_bad   = close && (rows != 5'd0) && (col_nxt != cols);
    rows_nxt    = close ? rows + 5'd1 : rows;
    cols_nxt    = (close && rows == 5'd0) ? col_nxt : cols;
    cnt_nxt     = wr_ptr + PW'(wr_en);
    first_word  = (wr_en && wr_ptr == '0) ? wdata : mem[0];
    ovf_nxt     = err_ovf | (acc && in_overflow);
    full_nxt    = err_full | (acc && !wr_en);
    shape_nxt   = err_shape | shape_bad;
    illegal_nxt = (state == COLLECT && in_busy) ? !in_legal : err_illegal;
    rd_nxt      = rd_ptr + PW'(1);
    rd_word     = mem[rd_nxt[AW-1:0]];
    rd_col_nxt  = (rd_col == cols - 5'd1) ? 5'd0 : rd_col + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      col_cnt     <= '0;
      rd_col      <= '0;
      rows        <= '0;
      cols        <= '0;
      err_ovf     <= 1'b0;
      err_shape   <= 1'b0;
      err_full    <= 1'b0;
      err_illegal <= 1'b0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_row_end   <= 1'b0;
      o_last      <= 1'b0;
      done        <= 1'b0;
`ifdef MMRC_HEADER_EN
      hdr_pend    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_busy) begin
            state       <= COLLECT;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            col_cnt     <= '0;
            rows        <= '0;
            cols        <= '0;
            err_ovf     <= 1'b0;
            err_shape   <= 1'b0;
            err_full    <= 1'b0;
            err_illegal <= 1'b0;
          end
        end
        COLLECT: begin
          wr_ptr      <= cnt_nxt;
          col_cnt     <= close ? 5'd0 : col_nxt;
          rows        <= rows_nxt;
          cols        <= cols_nxt;
          err_ovf     <= ovf_nxt;
          err_full    <= full_nxt;
          err_shape   <= shape_nxt;
          err_illegal <= illegal_nxt;
          // The first drain word is loaded on the same edge so it is visible one cycle after busy drops.
          if (!in_busy) begin
            state  <= DRAIN;
            rd_ptr <= '0;
            rd_col <= '0;
`ifdef MMRC_HEADER_EN
            hdr_pend  <= 1'b1;
            o_valid   <= 1'b1;
            o_data    <= header_word(full_nxt, illegal_nxt, shape_nxt, ovf_nxt, rows_nxt, cols_nxt);
            o_row_end <= 1'b0;
            o_last    <= (cnt_nxt == '0);
`else
            o_valid   <= (cnt_nxt != '0);
            o_data    <= first_word;
            o_row_end <= (cols_nxt == 5'd1);
            o_last    <= (cnt_nxt == PW'(1));
`endif
          end
        end
        DRAIN: begin
          if (!o_valid) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (o_ready) begin
            if (o_last) begin
              state     <= DONE;
              done      <= 1'b1;
              o_valid   <= 1'b0;
              o_data    <= '0;
              o_row_end <= 1'b0;
              o_last    <= 1'b0;
`ifdef MMRC_HEADER_EN
              hdr_pend  <= 1'b0;
`endif
            end
`ifdef MMRC_HEADER_EN
            else if (hdr_pend) begin
              hdr_pend  <= 1'b0;
              o_data    <= first_word;
              o_row_end <= (cols == 5'd1);
              o_last    <= (wr_ptr == PW'(1));
            end
`endif
            else begin
              rd_ptr    <= rd_nxt;
              rd_col    <= rd_col_nxt;
              o_data    <= rd_word;
              o_row_end <= (rd_col_nxt == cols - 5'd1);
              o_last    <= (rd_nxt == wr_ptr - PW'(1));
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_result_collector.sv
// Scoreboard bench for mm_result_collector: expected drain words are queued as elements are driven.
module tb_mm_result_collector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic signed [11:0] in_data = '0;
  logic in_overflow = 1'b0;
  logic in_change_row = 1'b0;
  logic in_legal = 1'b1;
  logic in_busy = 1'b0;
  logic o_ready = 1'b1;
  logic o_valid, o_row_end, o_last, done;
  logic signed [11:0] o_data;
  logic [4:0] rows, cols;
  logic err_ovf, err_shape, err_full, err_illegal;

`ifdef MMRC_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  always #5 clk = ~clk;

  mm_result_collector #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_overflow(in_overflow), .in_change_row(in_change_row), .in_legal(in_legal),
    .in_busy(in_busy), .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
    .o_row_end(o_row_end), .o_last(o_last), .rows(rows), .cols(cols),
    .err_ovf(err_ovf), .err_shape(err_shape), .err_full(err_full),
    .err_illegal(err_illegal), .done(done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  logic [13:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every valid cycle is checked against the queue head, so stalled words must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (o_valid) begin
        if (sb_q.size() == 0) chk("unexpected_valid", 32'(o_valid), 32'd0);
        else begin
          chk("o_data", {20'd0, o_data}, {20'd0, sb_q[0][11:0]});
          chk("o_row_end", 32'(o_row_end), 32'(sb_q[0][13]));
          chk("o_last", 32'(o_last), 32'(sb_q[0][12]));
          if (o_ready) begin
            void'(sb_q.pop_front());
            xfer_cnt++;
          end
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic legal);
    done_cnt = 0;
    xfer_cnt = 0;
    in_busy  = 1'b1;
    in_legal = legal;
    cyc();
  endtask

  task automatic push_hdr(input logic [11:0] h, input logic lst);
    sb_q.push_back({1'b0, lst, h});
  endtask

  task automatic send(input logic signed [11:0] d, input logic ovf, input logic chg,
                      input logic st, input logic re, input logic lst);
    logic [11:0] e;
    in_valid      = 1'b1;
    in_data       = d;
    in_overflow   = ovf;
    in_change_row = chg;
    e = ovf ? 12'd0 : d;
    if (st) sb_q.push_back({re, lst, e});
    cyc();
    in_valid      = 1'b0;
    in_overflow   = 1'b0;
    in_change_row = 1'b0;
  endtask

  task automatic end_job(input logic exp_valid);
    in_busy = 1'b0;
    cyc();
    chk("first_valid", 32'(o_valid), 32'(exp_valid));
  endtask

  task automatic wait_done;
    int t;
    t = 0;
    while (done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done), 32'd1);
    cyc();
  endtask

  task automatic post_checks(input logic [3:0] flags, input logic [4:0] r, input logic [4:0] c);
    repeat (2) cyc();
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("idle_valid", 32'(o_valid), 32'd0);
    chk("flags", 32'({err_full, err_illegal, err_shape, err_ovf}), 32'(flags));
    chk("rows", 32'(rows), 32'(r));
    chk("cols", 32'(cols), 32'(c));
  endtask

  task automatic job_basic(input logic ovf2);
    in_valid = 1'b1;
    in_data  = 12'sd99;
    cyc();
    in_valid = 1'b0;
    start_job(1'b1);
`ifdef MMRC_HEADER_EN
    push_hdr(ovf2 ? 12'h111 : 12'h011, 1'b0);
`endif
    send(12'sd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(-12'sd3, ovf2, 1'b1, 1'b1, 1'b1, 1'b0);
    send(12'sd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(12'sd2047, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    end_job(1'b1);
    wait_done();
    post_checks({3'b000, ovf2}, 5'd2, 5'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("reset_outputs", {2'd0, o_valid, o_data, o_row_end, o_last, done, rows, cols,
                          err_full, err_illegal, err_shape, err_ovf}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    job_basic(1'b0);
    job_basic(1'b1);

    // Empty job with an illegal shape reported while busy.
    start_job(1'b0);
    cyc();
`ifdef MMRC_HEADER_EN
    push_hdr(12'h4FF, 1'b1);
`endif
    end_job(HDR);
`ifdef MMRC_HEADER_EN
    wait_done();
`else
    chk("drain_no_done", 32'(done), 32'd0);
    cyc();
    chk("done_pulse", 32'(done), 32'd1);
    cyc();
    chk("done_clear", 32'(done), 32'd0);
`endif
    post_checks(4'b0100, 5'd0, 5'd0);
    in_legal = 1'b1;

    // 17x1 job into a 16-entry buffer.
    start_job(1'b1);
`ifdef MMRC_HEADER_EN
    push_hdr(12'h800, 1'b0);
`endif
    for (int i = 0; i < 17; i++)
      send(12'(i + 1), 1'b0, 1'b1, (i < 16), 1'b1, (i == 15));
    end_job(1'b1);
    wait_done();
    post_checks(4'b1000, 5'd17, 5'd1);

    // Ragged job: 2-wide row then a 1-element partial row closed at end.
    start_job(1'b1);
`ifdef MMRC_HEADER_EN
    push_hdr(12'h211, 1'b0);
`endif
    send(12'sd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(-12'sd22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    in_change_row = 1'b1;
    cyc();
    in_change_row = 1'b0;
    send(12'sd33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end_job(1'b1);
    wait_done();
    post_checks(4'b0010, 5'd2, 5'd2);

    // Stalled drain with reset landing after the second transfer.
    start_job(1'b1);
`ifdef MMRC_HEADER_EN
    push_hdr(12'h011, 1'b0);
`endif
    send(12'sd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(-12'sd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    send(12'sd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(12'sd2047, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    end_job(1'b1);
    for (int k = 0; k < 40; k++) begin
      o_ready = (k % 2 == 1);
      cyc();
      if (xfer_cnt >= 2) break;
    end
    chk("xfer_reached", 32'(xfer_cnt), 32'd2);
    rst = 1'b1;
    #1;
    chk("reset_mid_drain", {2'd0, o_valid, o_data, o_row_end, o_last, done, rows, cols,
                            err_full, err_illegal, err_shape, err_ovf}, 32'd0);
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    o_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post_reset_idle", 32'({o_valid, done}), 32'd0);
    end

    job_basic(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
